band_counter_mc: RTL

BAND_COUNTER_MC -- requirements
Module: band_counter_mc

---
 rtl/band_cnt_pkg.sv | 14 +
 rtl/band_cnt_ch.sv | 116 +++++++++++
 rtl/band_counter_mc.sv | 41 ++++
 3 files changed

// File: rtl/band_cnt_pkg.sv
// Shared definitions for the banded multi-channel counter.
// Mode encoding is fixed so that mode_i values map directly onto the enum.
package band_cnt_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    WRAP   = 2'd0,
    SAT    = 2'd1,
    BOUNCE = 2'd2,
    HOLD   = 2'd3
  } mode_e;

endpackage : band_cnt_pkg

// File: rtl/band_cnt_ch.sv
// One counter channel: bounded up-count with wrap, saturate, bounce or hold behaviour.
// All outputs are registered; arithmetic is one bit wider than the count to expose carry/borrow.
module band_cnt_ch
  import band_cnt_pkg::*;
#(
  parameter int REG_WD = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [REG_WD-1:0] step_i,
  input  logic [REG_WD-1:0] min_i,
  input  logic [REG_WD-1:0] max_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [REG_WD-1:0] cnt_o,
  output logic              dir_o,
  output logic              tc_o,
  output logic              cfg_err_o
);

  logic [REG_WD-1:0] cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              tc_q, tc_d;
  logic              err_q, err_d;
  logic [REG_WD:0]   sum, diff;
  logic              bad_cfg, out_of_band;
  mode_e             mode;

  assign mode        = mode_e'(mode_i);
  assign sum         = {1'b0, cnt_q} + {1'b0, step_i};
  assign diff        = {1'b0, cnt_q} - {1'b0, step_i};
  assign bad_cfg     = (min_i > max_i);
  assign out_of_band = (cnt_q < min_i) || (cnt_q > max_i);

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    err_d = bad_cfg;
    if (clr_i || bad_cfg) begin
      cnt_d = min_i;
      dir_d = 1'b0;
    end else if (en_i) begin
      if (out_of_band) begin
        // Bounds moved under a live count: re-anchor quietly at min.
        cnt_d = min_i;
        dir_d = 1'b0;
      end else begin
        if (mode == WRAP || mode == SAT) begin
          dir_d = 1'b0;
        end
        if (step_i != '0) begin
          case (mode)
            WRAP: begin
              if (sum > {1'b0, max_i}) begin
                cnt_d = min_i;
                tc_d  = 1'b1;
              end else begin
                cnt_d = sum[REG_WD-1:0];
              end
            end
            SAT: begin
              if (sum >= {1'b0, max_i}) begin
                cnt_d = max_i;
                tc_d  = (cnt_q < max_i);
              end else begin
                cnt_d = sum[REG_WD-1:0];
              end
            end
            BOUNCE: begin
              if (!dir_q) begin
                if (sum >= {1'b0, max_i}) begin
                  cnt_d = max_i;
                  dir_d = 1'b1;
                  tc_d  = 1'b1;
                end else begin
                  cnt_d = sum[REG_WD-1:0];
                end
              end else if (diff[REG_WD] || (diff[REG_WD-1:0] <= min_i)) begin
                cnt_d = min_i;
                dir_d = 1'b0;
                tc_d  = 1'b1;
              end else begin
                cnt_d = diff[REG_WD-1:0];
              end
            end
            default: begin
              cnt_d = cnt_q;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
      err_q <= err_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign dir_o     = dir_q;
  assign tc_o      = tc_q;
  assign cfg_err_o = err_q;

endmodule : band_cnt_ch

// File: rtl/band_counter_mc.sv
// N_CH independent banded counters sharing one clock and reset.
module band_counter_mc
  import band_cnt_pkg::*;
#(
  parameter int REG_WD = 8,
  parameter int N_CH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_CH-1:0]               en_i,
  input  logic [N_CH-1:0]               clr_i,
  input  logic [N_CH-1:0][REG_WD-1:0]   step_i,
  input  logic [N_CH-1:0][REG_WD-1:0]   min_i,
  input  logic [N_CH-1:0][REG_WD-1:0]   max_i,
  input  logic [N_CH-1:0][MODE_W-1:0]   mode_i,
  output logic [N_CH-1:0][REG_WD-1:0]   cnt_o,
  output logic [N_CH-1:0]               dir_o,
  output logic [N_CH-1:0]               tc_o,
  output logic [N_CH-1:0]               cfg_err_o
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
    band_cnt_ch #(
      .REG_WD(REG_WD)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i[gi]),
      .clr_i    (clr_i[gi]),
      .step_i   (step_i[gi]),
      .min_i    (min_i[gi]),
      .max_i    (max_i[gi]),
      .mode_i   (mode_i[gi]),
      .cnt_o    (cnt_o[gi]),
      .dir_o    (dir_o[gi]),
      .tc_o     (tc_o[gi]),
      .cfg_err_o(cfg_err_o[gi])
    );
  end

endmodule : band_counter_mc
